// File: rtl/demux1_16_regbank.sv
// rtl/demux1_16_regbank.sv - 1-to-16 write demultiplexer into a bank of sixteen registered entries
//
// Purpose: accepts one write per cycle over a valid/ready handshake, steers it
// with byte strobes into the entry selected by wr_sel, honours a per-entry write
// lock, and runs a 16-cycle clear-all sequence on request.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wr_valid  in   write request
//   wr_ready  out  write can be accepted this cycle (IDLE)
//   wr_sel    in   target entry 0..15
//   wr_data   in   write data
//   wr_be     in   byte enables, bit k covers wr_data[8k+7:8k]
//   wr_lock   in   per-entry write-protect mask
//   wr_ack    out  pulse: previous-cycle write committed
//   wr_err    out  pulse: previous-cycle write hit a locked entry
//   clr_req   in   clear-all request, sampled in IDLE only
//   busy      out  clear sequence in progress
//   out       out  current value of all sixteen entries
module demux1_16_regbank #(
  parameter  int WIDTH = 32,
  localparam int BE_W  = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [BE_W-1:0]  wr_be,
  input  logic [15:0]      wr_lock,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             clr_req,
  output logic             busy,
  output logic [WIDTH-1:0] out [16]
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q [16];
  logic [WIDTH-1:0] bank_d [16];
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             accept;

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);
  assign accept   = wr_valid & wr_ready;
  assign wr_ack   = ack_q;
  assign wr_err   = err_q;
  assign out      = bank_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    // Writes only land in IDLE, so they never collide with the clear below.
    if (accept) begin
      if (wr_lock[wr_sel]) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        for (int k = 0; k < BE_W; k++) begin
          if (wr_be[k]) bank_d[wr_sel][8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = 4'd0;
        end
      end
      CLEAR: begin
        // Clear ignores the lock mask; the counter wraps to 0 after entry 15.
        bank_d[cnt_q] = '0;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bank_q  <= '{default: '0};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_demux1_16_regbank.sv
// tb/tb_demux1_16_regbank.sv - self-checking bench for demux1_16_regbank
module tb_demux1_16_regbank;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [15:0] wr_lock;
  logic        wr_ack;
  logic        wr_err;
  logic        clr_req;
  logic        busy;
  logic [31:0] dout [16];

  int vectors;
  int miscompares;

  // Reference model: entry contents, clear progress, expected pulses.
  logic [31:0] exp_q [16];
  bit          m_busy;
  int          m_idx;
  bit          m_ack;
  bit          m_err;

  demux1_16_regbank #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .wr_lock  (wr_lock),
    .wr_ack   (wr_ack),
    .wr_err   (wr_err),
    .clr_req  (clr_req),
    .busy     (busy),
    .out      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_q[i] = 32'h0;
    m_busy = 0;
    m_idx  = 0;
    m_ack  = 0;
    m_err  = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    bit acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc   = wr_valid && !m_busy;
      m_ack = acc && !wr_lock[wr_sel];
      m_err = acc && wr_lock[wr_sel];
      if (m_ack)
        for (int k = 0; k < 4; k++)
          if (wr_be[k]) exp_q[wr_sel][8*k +: 8] = wr_data[8*k +: 8];
      if (m_busy) begin
        exp_q[m_idx] = 32'h0;
        m_idx = m_idx + 1;
        if (m_idx == 16) begin
          m_busy = 0;
          m_idx  = 0;
        end
      end else if (clr_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0;
    clr_req  = 0;
    wr_be    = 4'h0;
    wr_lock  = 16'h0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'($urandom); clr_req = 1'($urandom);
      wr_sel = 4'($urandom); wr_data = $urandom; wr_be = 4'($urandom); wr_lock = 16'($urandom);
      tick();
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (dout[i] !== 32'h0) begin
          miscompares++; $display("FAIL reset_out[%0d] got %h exp 00000000", i, dout[i]);
        end
      end
      vectors++;
      if ({wr_ready, busy, wr_ack, wr_err} !== 4'b1000) begin
        miscompares++; $display("FAIL reset_flags got %b exp 1000", {wr_ready, busy, wr_ack, wr_err});
      end
    end
    idle_inputs();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (dout[i] !== 32'h0) begin
          miscompares++; $display("FAIL post_reset_out[%0d] got %h exp 00000000", i, dout[i]);
        end
      end
      vectors++;
      if ({wr_ready, busy, wr_ack, wr_err} !== 4'b1000) begin
        miscompares++; $display("FAIL post_reset_flags got %b exp 1000", {wr_ready, busy, wr_ack, wr_err});
      end
    end
  endtask

  task automatic test_full_writes();
    wr_lock = 16'h0;
    wr_be   = 4'hF;
    for (int n = 0; n < 16; n++) begin
      wr_valid = 1; wr_sel = 4'(n); wr_data = 32'hA5A5_0000 + n;
      tick();
      vectors++;
      if (dout[n] !== 32'hA5A5_0000 + n) begin
        miscompares++; $display("FAIL full_write out[%0d] got %h exp %h", n, dout[n], 32'hA5A5_0000 + n);
      end
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (dout[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL full_model out[%0d] got %h exp %h", i, dout[i], exp_q[i]);
        end
      end
      vectors++;
      if ({wr_ready, busy, wr_ack, wr_err} !== 4'b1010) begin
        miscompares++; $display("FAIL full_flags got %b exp 1010", {wr_ready, busy, wr_ack, wr_err});
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if (wr_ack !== 1'b0) begin
      miscompares++; $display("FAIL full_ack_drop got %b exp 0", wr_ack);
    end
  endtask

  task automatic test_byte_enables();
    wr_valid = 1; wr_sel = 4'd3; wr_data = 32'h11223344; wr_be = 4'hF; wr_lock = 16'h0;
    tick();
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    tick();
    idle_inputs();
    vectors++;
    if (dout[3] !== 32'h11BB33DD) begin
      miscompares++; $display("FAIL byte_en out[3] got %h exp 11bb33dd", dout[3]);
    end
    vectors++;
    if (wr_ack !== 1'b1) begin
      miscompares++; $display("FAIL byte_en_ack got %b exp 1", wr_ack);
    end
    wr_valid = 1; wr_sel = 4'd3; wr_be = 4'h0; wr_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    vectors++;
    if ({wr_ack, dout[3]} !== {1'b1, 32'h11BB33DD}) begin
      miscompares++; $display("FAIL be_zero got ack=%b %h exp ack=1 11bb33dd", wr_ack, dout[3]);
    end
  endtask

  task automatic test_lock();
    logic [31:0] before7;
    before7 = exp_q[7];
    wr_valid = 1; wr_sel = 4'd7; wr_data = 32'hDEADBEEF; wr_be = 4'hF; wr_lock = 16'h0080;
    tick();
    vectors++;
    if ({wr_ack, wr_err, dout[7]} !== {2'b01, before7}) begin
      miscompares++; $display("FAIL lock got ack=%b err=%b %h exp ack=0 err=1 %h", wr_ack, wr_err, dout[7], before7);
    end
    wr_sel = 4'd6; wr_data = 32'h0606_0606;
    tick();
    idle_inputs();
    vectors++;
    if ({wr_ack, wr_err, dout[6], dout[7]} !== {2'b10, 32'h0606_0606, before7}) begin
      miscompares++; $display("FAIL lock_next got ack=%b err=%b %h %h exp ack=1 err=0 06060606 %h", wr_ack, wr_err, dout[6], dout[7], before7);
    end
    tick();
    vectors++;
    if ({wr_ack, wr_err} !== 2'b00) begin
      miscompares++; $display("FAIL lock_pulse_width got %b exp 00", {wr_ack, wr_err});
    end
  endtask

  task automatic test_clear_stall();
    int busy_cycles;
    bit done;
    for (int n = 0; n < 16; n++) begin
      wr_valid = 1; wr_sel = 4'(n); wr_data = $urandom | 32'h1; wr_be = 4'hF; wr_lock = 16'h0;
      tick();
    end
    idle_inputs();
    wr_lock = 16'($urandom) | 16'h8001;
    wr_lock[5] = 1'b0;
    clr_req = 1;
    tick();
    clr_req = 0;
    wr_valid = 1; wr_sel = 4'd5; wr_data = 32'h12345678; wr_be = 4'hF;
    busy_cycles = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (busy === 1'b1) busy_cycles++;
      vectors++;
      if (wr_ready !== !m_busy || busy !== m_busy) begin
        miscompares++; $display("FAIL clr_flags c=%0d got rdy=%b busy=%b exp rdy=%b busy=%b", c, wr_ready, busy, !m_busy, m_busy);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (dout[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL clr_out c=%0d out[%0d] got %h exp %h", c, i, dout[i], exp_q[i]);
        end
      end
      if (m_ack) done = 1;
    end
    idle_inputs();
    vectors++;
    if (!done) begin
      miscompares++; $display("FAIL clr_stall_timeout got no accept exp accept within 40 cycles");
    end
    vectors++;
    if (busy_cycles !== 16) begin
      miscompares++; $display("FAIL clr_busy_cycles got %0d exp 16", busy_cycles);
    end
    vectors++;
    if ({wr_ack, dout[5]} !== {1'b1, 32'h12345678}) begin
      miscompares++; $display("FAIL clr_stall_write got ack=%b %h exp ack=1 12345678", wr_ack, dout[5]);
    end
  endtask

  task automatic start_clear_with_write15();
    wr_valid = 1; wr_sel = 4'd15; wr_data = 32'hFFFFFFFF; wr_be = 4'hF; wr_lock = 16'h0;
    clr_req = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_clear_and_write();
    start_clear_with_write15();
    vectors++;
    if ({wr_ack, busy, dout[15]} !== {2'b11, 32'hFFFFFFFF}) begin
      miscompares++; $display("FAIL clrwr_start got ack=%b busy=%b %h exp ack=1 busy=1 ffffffff", wr_ack, busy, dout[15]);
    end
    for (int c = 1; c <= 16; c++) begin
      vectors++;
      if (dout[15] !== exp_q[15] || busy !== m_busy) begin
        miscompares++; $display("FAIL clrwr_seq c=%0d got %h busy=%b exp %h busy=%b", c, dout[15], busy, exp_q[15], m_busy);
      end
      clr_req = 1'($urandom);
      tick();
    end
    clr_req = 0;
    vectors++;
    if ({busy, wr_ready, dout[15]} !== {2'b01, 32'h0}) begin
      miscompares++; $display("FAIL clrwr_end got busy=%b rdy=%b %h exp busy=0 rdy=1 00000000", busy, wr_ready, dout[15]);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int n = 0; n < 16; n++) begin
      wr_valid = 1; wr_sel = 4'(n); wr_data = $urandom | 32'h100; wr_be = 4'hF; wr_lock = 16'h0;
      tick();
    end
    start_clear_with_write15();
    for (int c = 1; c < 8; c++) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL rstclr_pre busy got %b exp 1", busy);
    end
    rst_n = 0;
    #1;
    model_reset();
    vectors++;
    if ({busy, wr_ready, wr_ack, wr_err} !== 4'b0100) begin
      miscompares++; $display("FAIL rstclr_flags got %b exp 0100", {busy, wr_ready, wr_ack, wr_err});
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (dout[i] !== 32'h0) begin
        miscompares++; $display("FAIL rstclr_out[%0d] got %h exp 00000000", i, dout[i]);
      end
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_valid = ($urandom_range(3) != 0);
      wr_sel   = 4'($urandom);
      wr_data  = $urandom;
      wr_be    = 4'($urandom);
      wr_lock  = 16'($urandom & $urandom);
      clr_req  = ($urandom_range(31) == 0);
      tick();
      vectors++;
      if ({wr_ready, busy, wr_ack, wr_err} !== {!m_busy, m_busy, m_ack, m_err}) begin
        miscompares++; $display("FAIL rand_flags c=%0d got %b exp %b", c, {wr_ready, busy, wr_ack, wr_err}, {!m_busy, m_busy, m_ack, m_err});
      end
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (dout[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand_out c=%0d out[%0d] got %h exp %h", c, i, dout[i], exp_q[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 0;
    wr_sel = 4'h0;
    wr_data = 32'h0;
    idle_inputs();
    model_reset();
    test_reset();
    test_full_writes();
    test_byte_enables();
    test_lock();
    test_clear_stall();
    test_clear_and_write();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
